// File: rtl/door_if.sv
// Door sequencer handshake bundle: arrival request and button levels in,
// LED / door-open / busy / done indications out.
// DOOR_OBSTRUCT_EN adds the obstruct sensor signal.
interface door_if;
    logic arrive;
    logic open_btn;
    logic close_btn;
`ifdef DOOR_OBSTRUCT_EN
    logic obstruct;
`endif
    logic door_led;
    logic door_open;
    logic busy;
    logic done;

    // Motion controller / car panel side
    modport master (
`ifdef DOOR_OBSTRUCT_EN
        output obstruct,
`endif
        output arrive,
        output open_btn,
        output close_btn,
        input  door_led,
        input  door_open,
        input  busy,
        input  done
    );

    // Door sequencer side
    modport slave (
`ifdef DOOR_OBSTRUCT_EN
        input  obstruct,
`endif
        input  arrive,
        input  open_btn,
        input  close_btn,
        output door_led,
        output door_open,
        output busy,
        output done
    );
endinterface

// File: rtl/door_sequencer.sv
// Door sequencer: IDLE -> OPEN_BLINK -> HOLD -> CLOSE_BLINK -> IDLE.
// The LED toggles once per tick (TICK_MAX cycles) in both blink phases. The
// hold can be restarted (open_btn), cut short (close_btn) or re-entered from
// the closing blink (open_btn). All outputs are registered (Moore).
// Optional feature macro: DOOR_OBSTRUCT_EN (obstruct sensor input).
module door_sequencer #(
    parameter int unsigned TICK_MAX     = 50000000,
    parameter int unsigned BLINKS       = 3,
    parameter int unsigned HOLD_TICKS   = 4,
    parameter int unsigned CLOSE_BLINKS = 2
) (
    input logic   clk,
    input logic   rst_n,
    door_if.slave door_io
);

    localparam int unsigned TickW = $clog2(TICK_MAX);

    localparam int unsigned OpenTicks  = 2 * BLINKS;
    localparam int unsigned CloseTicks = 2 * CLOSE_BLINKS;
    localparam int unsigned PhaseMax01 = (OpenTicks > HOLD_TICKS) ? OpenTicks : HOLD_TICKS;
    localparam int unsigned PhaseMax   = (PhaseMax01 > CloseTicks) ? PhaseMax01 : CloseTicks;
    localparam int unsigned PhaseW     = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;

    // Phase value held during the last tick of each state
    localparam logic [PhaseW-1:0] OpenLast  = PhaseW'(OpenTicks - 1);
    localparam logic [PhaseW-1:0] HoldLast  = PhaseW'(HOLD_TICKS - 1);
    localparam logic [PhaseW-1:0] CloseLast = PhaseW'(CloseTicks - 1);
    localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_MAX - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOpenBlink,
        StHold,
        StCloseBlink
    } state_e;

    state_e            state_q, state_d;
    logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic              door_led_q, door_led_d;
    logic              door_open_q, door_open_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic tick;
    logic obstruct;
    logic reopen;

`ifdef DOOR_OBSTRUCT_EN
    assign obstruct = door_io.obstruct;
`else
    assign obstruct = 1'b0;
`endif

    assign tick   = (tick_cnt_q == TickLast);
    // Obstruction acts like a held open button in HOLD and CLOSE_BLINK
    assign reopen = door_io.open_btn | obstruct;

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TickW'(1);
        phase_d     = tick ? phase_q + PhaseW'(1) : phase_q;
        door_led_d  = door_led_q;
        door_open_d = door_open_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                tick_cnt_d = '0;
                phase_d    = '0;
                if (door_io.arrive) begin
                    state_d    = StOpenBlink;
                    door_led_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            StOpenBlink: begin
                if (tick) begin
                    door_led_d = ~door_led_q;
                    if (phase_q == OpenLast) begin
                        state_d     = StHold;
                        door_led_d  = 1'b1;
                        door_open_d = 1'b1;
                        tick_cnt_d  = '0;
                        phase_d     = '0;
                    end
                end
            end
            StHold: begin
                if (reopen) begin
                    tick_cnt_d = '0;
                    phase_d    = '0;
                end else if (door_io.close_btn || (tick && phase_q == HoldLast)) begin
                    state_d     = StCloseBlink;
                    door_led_d  = 1'b0;
                    door_open_d = 1'b0;
                    tick_cnt_d  = '0;
                    phase_d     = '0;
                end
            end
            StCloseBlink: begin
                if (reopen) begin
                    state_d     = StHold;
                    door_led_d  = 1'b1;
                    door_open_d = 1'b1;
                    tick_cnt_d  = '0;
                    phase_d     = '0;
                end else if (tick) begin
                    door_led_d = ~door_led_q;
                    if (phase_q == CloseLast) begin
                        state_d    = StIdle;
                        door_led_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        tick_cnt_d = '0;
                        phase_d    = '0;
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                door_led_d  = 1'b0;
                door_open_d = 1'b0;
                busy_d      = 1'b0;
                tick_cnt_d  = '0;
                phase_d     = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            phase_q     <= '0;
            door_led_q  <= 1'b0;
            door_open_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            phase_q     <= phase_d;
            door_led_q  <= door_led_d;
            door_open_q <= door_open_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign door_io.door_led  = door_led_q;
    assign door_io.door_open = door_open_q;
    assign door_io.busy      = busy_q;
    assign door_io.done      = done_q;

endmodule

// File: tb/tb_door_sequencer.sv
// Directed bench for door_sequencer with TICK_MAX=4, BLINKS=3, HOLD_TICKS=4,
// CLOSE_BLINKS=2. Observed vector is {busy, done, door_open, door_led}.
// Cycle c is the interval after edge c-1; inputs set during cycle c are
// sampled at the edge that ends it and show up in cycle c+1.
module tb_door_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc;
    int   n_checks = 0;
    int   n_errors = 0;

    door_if u_if ();

    door_sequencer #(
        .TICK_MAX    (4),
        .BLINKS      (3),
        .HOLD_TICKS  (4),
        .CLOSE_BLINKS(2)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .door_io(u_if.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] obs();
        return {u_if.busy, u_if.done, u_if.door_open, u_if.door_led};
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    // Arrive present during cycle 0, so the sequence is visible from cycle 1
    task automatic start();
        cyc = 0;
        u_if.arrive = 1'b1;
        step();
        u_if.arrive = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((u_if.busy || u_if.done) && n < 200) begin
            step();
            n++;
        end
        check(tag, obs(), 4'b0000);
    endtask

    // Basic cycle: {cycle, expected vector}
    localparam int BasicN = 18;
    int         bc_cyc [BasicN] = '{1, 4, 5, 8, 9, 21, 24, 25, 40, 41, 44, 45, 48, 49, 53, 56, 57, 58};
    logic [3:0] bc_exp [BasicN] = '{4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b1001, 4'b1000,
                                    4'b1000, 4'b1011, 4'b1011, 4'b1000, 4'b1000, 4'b1001,
                                    4'b1001, 4'b1000, 4'b1001, 4'b1001, 4'b0100, 4'b0000};

    task automatic run_basic(input string tag);
        start();
        for (int i = 0; i < BasicN; i++) begin
            goto(bc_cyc[i]);
            check(tag, obs(), bc_exp[i]);
        end
    endtask

    initial begin
        cyc            = 0;
        rst_n          = 1'b0;
        u_if.arrive    = 1'b0;
        u_if.open_btn  = 1'b0;
        u_if.close_btn = 1'b0;
`ifdef DOOR_OBSTRUCT_EN
        u_if.obstruct  = 1'b0;
`endif
        repeat (3) step();
        check("reset", obs(), 4'b0000);
        rst_n = 1'b1;
        step();
        check("idle_after_reset", obs(), 4'b0000);

        run_basic("basic");

        // Hold extension: open_btn during cycle 30
        start();
        goto(30);
        u_if.open_btn = 1'b1;
        step();
        u_if.open_btn = 1'b0;
        check("ext_31", obs(), 4'b1011);
        goto(46);
        check("ext_46", obs(), 4'b1011);
        goto(47);
        check("ext_47", obs(), 4'b1000);
        wait_idle("ext_idle");

        // Early close at cycle 27; arrive during CLOSE_BLINK is not queued
        start();
        goto(27);
        check("close_27", obs(), 4'b1011);
        u_if.close_btn = 1'b1;
        step();
        u_if.close_btn = 1'b0;
        check("close_28", obs(), 4'b1000);
        goto(30);
        u_if.arrive = 1'b1;
        step();
        u_if.arrive = 1'b0;
        goto(32);
        check("close_32", obs(), 4'b1001);
        goto(43);
        check("close_43", obs(), 4'b1001);
        goto(44);
        check("close_done", obs(), 4'b0100);
        goto(46);
        check("arrive_not_queued", obs(), 4'b0000);

        // open_btn beats close_btn in HOLD
        start();
        goto(27);
        u_if.close_btn = 1'b1;
        u_if.open_btn  = 1'b1;
        step();
        u_if.close_btn = 1'b0;
        u_if.open_btn  = 1'b0;
        check("prio_28", obs(), 4'b1011);
        goto(43);
        check("prio_43", obs(), 4'b1011);
        goto(44);
        check("prio_44", obs(), 4'b1000);
        wait_idle("prio_idle");

        // Reopen from CLOSE_BLINK at cycle 45
        start();
        goto(45);
        check("reopen_45", obs(), 4'b1001);
        u_if.open_btn = 1'b1;
        step();
        u_if.open_btn = 1'b0;
        check("reopen_46", obs(), 4'b1011);
        goto(61);
        check("reopen_61", obs(), 4'b1011);
        goto(62);
        check("reopen_62", obs(), 4'b1000);
        goto(78);
        check("reopen_done", obs(), 4'b0100);
        wait_idle("reopen_idle");

        // Reset mid-sequence, arrive held while in reset
        start();
        goto(10);
        rst_n       = 1'b0;
        u_if.arrive = 1'b1;
        step();
        check("rst_11", obs(), 4'b0000);
        step();
        check("rst_12", obs(), 4'b0000);
        rst_n       = 1'b1;
        u_if.arrive = 1'b0;
        step();
        check("rst_13", obs(), 4'b0000);
        run_basic("after_rst");

        // Back-to-back: arrive during the done cycle
        start();
        goto(57);
        check("b2b_57", obs(), 4'b0100);
        u_if.arrive = 1'b1;
        step();
        u_if.arrive = 1'b0;
        check("b2b_58", obs(), 4'b1001);
        wait_idle("b2b_idle");

`ifdef DOOR_OBSTRUCT_EN
        // Obstruct during cycles 41-50, close_btn pressed meanwhile
        start();
        goto(41);
        u_if.obstruct = 1'b1;
        step();
        check("obs_42", obs(), 4'b1011);
        goto(45);
        u_if.close_btn = 1'b1;
        step();
        u_if.close_btn = 1'b0;
        check("obs_46", obs(), 4'b1011);
        goto(50);
        step();
        u_if.obstruct = 1'b0;
        goto(66);
        check("obs_66", obs(), 4'b1011);
        goto(67);
        check("obs_67", obs(), 4'b1000);
        wait_idle("obs_idle");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
